// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller and the DDS sine generator.
package dds_pkg;

  localparam int unsigned W_ACC_DEF = 32;

  typedef enum logic [1:0] {
    MODE_SINGLE   = 2'd0,
    MODE_REPEAT   = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;

endpackage

// File: rtl/dds_step_next.sv
// Next tuning word toward an end word; one extra bit catches carry/borrow so the
// result clamps to the end word instead of wrapping.
module dds_step_next
  import dds_pkg::*;
#(
  parameter int unsigned W = W_ACC_DEF
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] delta,
  input  logic [W-1:0] end_word,
  input  logic         dir,
  output logic [W-1:0] nxt,
  output logic         at_end
);

  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    sum  = {1'b0, cur} + {1'b0, delta};
    diff = {1'b0, cur} - {1'b0, delta};
    nxt  = end_word;
    if (dir == DIR_UP) begin
      if (!sum[W] && (sum[W-1:0] <= end_word)) nxt = sum[W-1:0];
    end else begin
      if (!diff[W] && (diff[W-1:0] >= end_word)) nxt = diff[W-1:0];
    end
    at_end = (cur == end_word);
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS tuning word between start and stop,
// holding each word for dwell+1 cycles, in single, repeat or triangle mode.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned W_ACC   = W_ACC_DEF,
  parameter int unsigned W_DWELL = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [W_ACC-1:0]   cfg_start,
  input  logic [W_ACC-1:0]   cfg_stop,
  input  logic [W_ACC-1:0]   cfg_delta,
  input  logic [W_DWELL-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [W_ACC-1:0]   cfg_phase,
  input  logic               start,
  input  logic               abort,
  output logic [W_ACC-1:0]   step_out,
  output logic [W_ACC-1:0]   phase_out,
  output logic               busy,
  output logic               done
);

  state_t             state, state_n;
  logic [W_ACC-1:0]   sh_start, sh_stop, sh_delta, sh_phase;
  logic [W_DWELL-1:0] sh_dwell;
  mode_t              sh_mode;

  logic [W_ACC-1:0]   leg_begin, leg_end, begin_n, end_n, step_n;
  logic               dir, dir_n;
  logic [W_DWELL-1:0] dwell_cnt, dwell_n;
  logic               busy_n, done_n, ready_n;

  logic [W_ACC-1:0]   nxt_fwd, nxt_rev;
  logic               at_end;
  logic               unused_rev_at_end;

  dds_step_next #(.W(W_ACC)) u_fwd (
    .cur      (step_out),
    .delta    (sh_delta),
    .end_word (leg_end),
    .dir      (dir),
    .nxt      (nxt_fwd),
    .at_end   (at_end)
  );

  // Triangle turnaround: the first word of the return leg comes straight off the
  // end word, so the end word is held only one dwell period.
  dds_step_next #(.W(W_ACC)) u_rev (
    .cur      (step_out),
    .delta    (sh_delta),
    .end_word (leg_begin),
    .dir      (~dir),
    .nxt      (nxt_rev),
    .at_end   (unused_rev_at_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_start  <= '0;
      sh_stop   <= '0;
      sh_delta  <= '0;
      sh_dwell  <= '0;
      sh_mode   <= MODE_SINGLE;
      sh_phase  <= '0;
      phase_out <= '0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        sh_start <= cfg_start;
        sh_stop  <= cfg_stop;
        sh_delta <= cfg_delta;
        sh_dwell <= cfg_dwell;
        sh_mode  <= mode_t'(cfg_mode);
        sh_phase <= cfg_phase;
      end
      phase_out <= sh_phase;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      step_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
      dwell_cnt <= '0;
      leg_begin <= '0;
      leg_end   <= '0;
      dir       <= DIR_UP;
    end else begin
      state     <= state_n;
      step_out  <= step_n;
      busy      <= busy_n;
      done      <= done_n;
      cfg_ready <= ready_n;
      dwell_cnt <= dwell_n;
      leg_begin <= begin_n;
      leg_end   <= end_n;
      dir       <= dir_n;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step_out;
    busy_n  = busy;
    done_n  = 1'b0;
    dwell_n = dwell_cnt;
    begin_n = leg_begin;
    end_n   = leg_end;
    dir_n   = dir;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_RUN;
          step_n  = sh_start;
          busy_n  = 1'b1;
          dwell_n = sh_dwell;
          begin_n = sh_start;
          end_n   = sh_stop;
          dir_n   = (sh_start <= sh_stop);
        end
      end
      ST_RUN: begin
        if (dwell_cnt != '0) begin
          dwell_n = dwell_cnt - 1'b1;
        end else if (!at_end) begin
          step_n  = nxt_fwd;
          dwell_n = sh_dwell;
        end else begin
          case (sh_mode)
            MODE_REPEAT: begin
              step_n  = leg_begin;
              dwell_n = sh_dwell;
            end
            MODE_TRIANGLE: begin
              step_n  = nxt_rev;
              dwell_n = sh_dwell;
              begin_n = leg_end;
              end_n   = leg_begin;
              dir_n   = ~dir;
            end
            default: begin
              state_n = ST_DONE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
          endcase
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (abort) begin
      state_n = ST_IDLE;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      step_n  = step_out;
    end
    ready_n = (state_n == ST_IDLE);
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected per-cycle outputs are queued at
// stimulus time and popped by a monitor on every cycle where busy or done is high.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready, start, abort, busy, done;
  logic [31:0] cfg_start, cfg_stop, cfg_delta, cfg_phase, step_out, phase_out;
  logic [23:0] cfg_dwell;
  logic [1:0]  cfg_mode;

  typedef struct packed {
    logic [31:0] step;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.W_ACC(32), .W_DWELL(24)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_delta (cfg_delta),
    .cfg_dwell (cfg_dwell),
    .cfg_mode  (cfg_mode),
    .cfg_phase (cfg_phase),
    .start     (start),
    .abort     (abort),
    .step_out  (step_out),
    .phase_out (phase_out),
    .busy      (busy),
    .done      (done)
  );

  always @(negedge clk) begin
    if (rst_n && (busy || done)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output actual step=%h busy=%b done=%b required no activity",
                 step_out, busy, done);
      end else begin
        e = q.pop_front();
        if (step_out !== e.step || busy !== e.busy || done !== e.done) begin
          fails++;
          $display("FAIL scoreboard actual step=%h busy=%b done=%b required step=%h busy=%b done=%b",
                   step_out, busy, done, e.step, e.busy, e.done);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] s, input logic b, input logic d);
    q.push_back({s, b, d});
  endtask

  task automatic push_run(input logic [31:0] s, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push(s, 1'b1, 1'b0);
  endtask

  // Called just after a posedge with the DUT idle.
  task automatic configure(input logic [31:0] s, input logic [31:0] p, input logic [31:0] d,
                           input logic [23:0] dw, input logic [1:0] m, input logic [31:0] ph);
    chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
    cfg_start = s; cfg_stop = p; cfg_delta = d; cfg_dwell = dw; cfg_mode = m; cfg_phase = ph;
    cfg_valid = 1'b1;
    @(posedge clk); #1 cfg_valid = 1'b0;
    @(posedge clk); #1;
    chk("phase_after_accept", phase_out, ph);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_start = '0; cfg_stop = '0; cfg_delta = '0; cfg_dwell = '0; cfg_mode = '0; cfg_phase = '0;
    #23;
    chk("rst_step", step_out, 32'd0);
    chk("rst_phase", phase_out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // start with shadow regs at reset: start=stop=0, single, dwell 0
    push(32'd0, 1'b1, 1'b0);
    push(32'd0, 1'b0, 1'b1);
    do_start();
    drain("t1_drain");

    // single up, with a start pulse during the run that must be ignored
    configure(32'd100, 32'd130, 32'd10, 24'd2, 2'd0, 32'h0000_1234);
    push_run(32'd100, 3); push_run(32'd110, 3); push_run(32'd120, 3); push_run(32'd130, 3);
    push(32'd130, 1'b0, 1'b1);
    do_start();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain("t2_drain");

    // overflow clamp, reserved mode behaves as single
    configure(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd0, 2'd3, 32'h0000_1234);
    push(32'hFFFF_FFF0, 1'b1, 1'b0);
    push(32'hFFFF_FFFF, 1'b1, 1'b0);
    push(32'hFFFF_FFFF, 1'b0, 1'b1);
    do_start();
    drain("t3_drain");

    // triangle, aborted while the word is 4
    configure(32'd0, 32'd4, 32'd2, 24'd0, 2'd2, 32'h0000_1234);
    push_run(32'd0, 1); push_run(32'd2, 1); push_run(32'd4, 1); push_run(32'd2, 1);
    push_run(32'd0, 1); push_run(32'd2, 1); push_run(32'd4, 1);
    do_start();
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("t4_frozen_step", step_out, 32'd4);
    chk("t4_busy_off", {31'd0, busy}, 32'd0);
    chk("t4_no_done", {31'd0, done}, 32'd0);
    drain("t4_drain");

    // abort together with start in idle: start ignored
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_beats_start", {31'd0, busy}, 32'd0);
    chk("abort_start_step", step_out, 32'd4);
    @(posedge clk); #1;

    // repeat down with clamp to 30
    configure(32'd50, 32'd30, 32'd15, 24'd1, 2'd1, 32'h0000_1234);
    for (int unsigned r = 0; r < 2; r++) begin
      push_run(32'd50, 2); push_run(32'd35, 2); push_run(32'd30, 2);
    end
    do_start();
    repeat (11) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("t5_frozen_step", step_out, 32'd30);
    drain("t5_drain");

    // handshake stall while running; accept once idle returns
    configure(32'd7, 32'd7, 32'd1, 24'd3, 2'd0, 32'h0000_1234);
    push_run(32'd7, 4);
    push(32'd7, 1'b0, 1'b1);
    do_start();
    cfg_start = 32'd999; cfg_stop = 32'd999; cfg_delta = 32'd0; cfg_dwell = 24'd0;
    cfg_mode = 2'd0; cfg_phase = 32'h4000_0000; cfg_valid = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6_stall_ready", {31'd0, cfg_ready}, 32'd0);
      chk("t6_stall_phase", phase_out, 32'h0000_1234);
    end
    @(negedge clk);
    chk("t6_ready_back", {31'd0, cfg_ready}, 32'd1);
    @(posedge clk); #1 cfg_valid = 1'b0;
    @(negedge clk);
    chk("t6_phase_not_yet", phase_out, 32'h0000_1234);
    @(negedge clk);
    chk("t6_phase_new", phase_out, 32'h4000_0000);
    drain("t6_drain");
    push(32'd999, 1'b1, 1'b0);
    push(32'd999, 1'b0, 1'b1);
    do_start();
    drain("t6_new_cfg_drain");

    // async reset mid-sweep
    configure(32'd100, 32'd130, 32'd10, 24'd2, 2'd1, 32'h0000_0055);
    push_run(32'd100, 3); push_run(32'd110, 2);
    do_start();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_step", step_out, 32'd0);
    chk("arst_phase", phase_out, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("arst_queue", q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("final_idle_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
